// File: rtl/stream_pkg.sv
// Shared stream width-conversion types and helpers, used by both the upsizer and downsizer.
// Lane width and ratio are fixed here so count_t and pad_word have one definition.
package stream_pkg;

    localparam int unsigned StreamInW   = 4;
    localparam int unsigned StreamRatio = 4;
    localparam int unsigned StreamOutW  = StreamInW * StreamRatio;
    localparam int unsigned CountW      = $clog2(StreamRatio + 1);

    typedef logic [CountW-1:0]     count_t;
    typedef logic [StreamOutW-1:0] word_t;

    // Keep lanes 0..k of acc; lanes above k become zero or copies of msb.
    function automatic word_t pad_word(word_t acc, count_t k, logic msb, logic sign_ext);
        word_t res;
        res = acc;
        for (int i = 0; i < StreamRatio; i++) begin
            if (i > int'(k)) begin
                res[i*StreamInW +: StreamInW] = sign_ext ? {StreamInW{msb}} : '0;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Valid/ready holding register for a packed word plus its beat count and last flag.
// A load always wins over a pop, so back-to-back words keep valid asserted.
module stream_out_reg
    import stream_pkg::*;
#(
    parameter int unsigned W = StreamOutW
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  count_t       count_i,
    input  logic         last_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output count_t       count_o,
    output logic         last_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            count_o <= '0;
            last_o  <= 1'b0;
        end else if (load_i) begin
            valid_o <= 1'b1;
            data_o  <= data_i;
            count_o <= count_i;
            last_o  <= last_i;
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_upsizer.sv
// Packs IN_W-bit beats into IN_W*RATIO-bit words, beat 0 in the low lane.
// A last beat flushes a partial word with zero or sign padding above it.
module stream_upsizer
    import stream_pkg::*;
#(
    parameter int unsigned IN_W     = StreamInW,
    parameter int unsigned RATIO    = StreamRatio,
    parameter bit          SIGN_EXT = 1'b0,
    localparam int unsigned OUT_W   = IN_W * RATIO
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [IN_W-1:0]  in_data_i,
    input  logic             in_last_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] out_data_o,
    output count_t           out_count_o,
    output logic             out_last_o
);

    count_t           fill_q, fill_d;
    logic [OUT_W-1:0] acc_q, acc_d, acc_with;
    logic             accept, complete;

    assign in_ready_o = !rst_i && (!out_valid_o || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    assign complete   = accept && ((fill_q == count_t'(RATIO - 1)) || in_last_i);

    always_comb begin
        acc_with = acc_q;
        acc_with[fill_q*IN_W +: IN_W] = in_data_i;
        acc_d  = acc_q;
        fill_d = fill_q;
        if (complete) begin
            acc_d  = acc_with;
            fill_d = '0;
        end else if (accept) begin
            acc_d  = acc_with;
            fill_d = fill_q + count_t'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fill_q <= '0;
            acc_q  <= '0;
        end else begin
            fill_q <= fill_d;
            acc_q  <= acc_d;
        end
    end

    stream_out_reg #(
        .W (OUT_W)
    ) u_out_reg (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (complete),
        .data_i  (pad_word(acc_with, fill_q, in_data_i[IN_W-1], SIGN_EXT)),
        .count_i (fill_q + count_t'(1)),
        .last_i  (in_last_i),
        .ready_i (out_ready_i),
        .valid_o (out_valid_o),
        .data_o  (out_data_o),
        .count_o (out_count_o),
        .last_o  (out_last_o)
    );

endmodule

// File: tb/tb_stream_upsizer.sv
// Directed bench for stream_upsizer: zero-pad and sign-pad instances share one stimulus.
module tb_stream_upsizer;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_last, out_ready;
    logic [3:0]  in_data;
    logic        in_ready0, in_ready1, out_valid0, out_valid1, out_last0, out_last1;
    logic [15:0] out_data0, out_data1;
    logic [2:0]  out_count0, out_count1;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    stream_upsizer #(.IN_W(4), .RATIO(4), .SIGN_EXT(1'b0)) dut0 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready0),
        .in_data_i(in_data), .in_last_i(in_last), .out_valid_o(out_valid0),
        .out_ready_i(out_ready), .out_data_o(out_data0), .out_count_o(out_count0),
        .out_last_o(out_last0)
    );

    stream_upsizer #(.IN_W(4), .RATIO(4), .SIGN_EXT(1'b1)) dut1 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready1),
        .in_data_i(in_data), .in_last_i(in_last), .out_valid_o(out_valid1),
        .out_ready_i(out_ready), .out_data_o(out_data1), .out_count_o(out_count1),
        .out_last_o(out_last1)
    );

    typedef struct {
        logic [15:0] beats;  // beat i in nibble i
        int          n;
        logic        has_last;
        logic [15:0] exp0;
        logic [15:0] exp1;
        logic [2:0]  exp_cnt;
        logic        exp_last;
    } vec_t;

    vec_t        vecs [7];
    logic [15:0] words [$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_packet(input logic [15:0] beats, input int n, input logic with_last);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = beats[i*4 +: 4];
            in_last  = with_last && (i == n - 1);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, "_valid0"}, 32'(out_valid0), 32'd0);
        check({tag, "_valid1"}, 32'(out_valid1), 32'd0);
        check({tag, "_data0"}, 32'(out_data0), 32'd0);
        check({tag, "_data1"}, 32'(out_data1), 32'd0);
        check({tag, "_count0"}, 32'(out_count0), 32'd0);
        check({tag, "_last0"}, 32'(out_last0), 32'd0);
        check({tag, "_in_ready0"}, 32'(in_ready0), 32'd0);
        check({tag, "_in_ready1"}, 32'(in_ready1), 32'd0);
    endtask

    initial begin
        vecs[0] = '{16'h4321, 4, 1'b0, 16'h4321, 16'h4321, 3'd4, 1'b0};
        vecs[1] = '{16'h005A, 2, 1'b1, 16'h005A, 16'h005A, 3'd2, 1'b1};
        vecs[2] = '{16'h00C3, 2, 1'b1, 16'h00C3, 16'hFFC3, 3'd2, 1'b1};
        vecs[3] = '{16'h0043, 2, 1'b1, 16'h0043, 16'h0043, 3'd2, 1'b1};
        vecs[4] = '{16'h000F, 1, 1'b1, 16'h000F, 16'hFFFF, 3'd1, 1'b1};
        vecs[5] = '{16'h4321, 4, 1'b1, 16'h4321, 16'h4321, 3'd4, 1'b1};
        vecs[6] = '{16'h0918, 3, 1'b1, 16'h0918, 16'hF918, 3'd3, 1'b1};

        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
        step();
        step();
        check_idle_reset("reset");
        rst = 1'b0;
        #1;
        check("ready_after_reset", 32'(in_ready0), 32'd1);

        for (int v = 0; v < 7; v++) begin
            send_packet(vecs[v].beats, vecs[v].n, vecs[v].has_last);
            check($sformatf("vec%0d_valid0", v), 32'(out_valid0), 32'd1);
            check($sformatf("vec%0d_valid1", v), 32'(out_valid1), 32'd1);
            check($sformatf("vec%0d_data0", v), 32'(out_data0), 32'(vecs[v].exp0));
            check($sformatf("vec%0d_data1", v), 32'(out_data1), 32'(vecs[v].exp1));
            check($sformatf("vec%0d_count0", v), 32'(out_count0), 32'(vecs[v].exp_cnt));
            check($sformatf("vec%0d_count1", v), 32'(out_count1), 32'(vecs[v].exp_cnt));
            check($sformatf("vec%0d_last0", v), 32'(out_last0), 32'(vecs[v].exp_last));
            step();
            check($sformatf("vec%0d_drop", v), 32'(out_valid0), 32'd0);
        end

        // Backpressure: held word must stay put and block further beats.
        out_ready = 1'b0;
        send_packet(16'h4321, 4, 1'b0);
        in_valid = 1'b1; in_data = 4'h9; in_last = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("bp_in_ready", 32'(in_ready0), 32'd0);
            step();
            check("bp_valid", 32'(out_valid0), 32'd1);
            check("bp_data", 32'(out_data0), 32'h4321);
            check("bp_count", 32'(out_count0), 32'd4);
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready0), 32'd1);
        step();
        check("bp_popped", 32'(out_valid0), 32'd0);
        send_packet(16'h8765, 4, 1'b0);
        check("bp_next_word", 32'(out_data0), 32'h8765);
        step();

        // Back-to-back streaming of 8 beats must yield exactly two words.
        words.delete();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 4'(i + 1); in_last = 1'b0;
            step();
            if (out_valid0) words.push_back(out_data0);
        end
        in_valid = 1'b0;
        step();
        if (out_valid0) words.push_back(out_data0);
        check("stream_words", 32'(words.size()), 32'd2);
        if (words.size() == 2) begin
            check("stream_w0", 32'(words[0]), 32'h4321);
            check("stream_w1", 32'(words[1]), 32'h8765);
        end

        // Pop and completion on the same edge keep valid high.
        in_valid = 1'b1; in_data = 4'hF; in_last = 1'b1;
        step();
        check("popload_first", 32'(out_data0), 32'h000F);
        in_data = 4'hE;
        check("popload_ready", 32'(in_ready0), 32'd1);
        step();
        in_valid = 1'b0; in_last = 1'b0;
        check("popload_valid", 32'(out_valid0), 32'd1);
        check("popload_data0", 32'(out_data0), 32'h000E);
        check("popload_data1", 32'(out_data1), 32'hFFFE);
        check("popload_count", 32'(out_count1), 32'd1);
        step();
        check("popload_drop", 32'(out_valid0), 32'd0);

        // Reset with a word pending drops it.
        out_ready = 1'b0;
        send_packet(16'h4321, 4, 1'b0);
        rst = 1'b1;
        step();
        check_idle_reset("rst_pending");
        rst = 1'b0; out_ready = 1'b1;

        // Reset mid-fill discards the partial beats.
        send_packet(16'h0021, 2, 1'b0);
        rst = 1'b1;
        step();
        check_idle_reset("rst_midfill");
        rst = 1'b0;
        words.delete();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 4'(7 + i); in_last = 1'b0;
            step();
            if (out_valid0) words.push_back(out_data0);
        end
        in_valid = 1'b0;
        check("midfill_count", 32'(out_count0), 32'd4);
        step();
        if (out_valid0) words.push_back(out_data0);
        check("midfill_words", 32'(words.size()), 32'd1);
        if (words.size() == 1) check("midfill_w0", 32'(words[0]), 32'hA987);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
